// File: rtl/wave_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_ctrl_pkg
//  Description : Shared command, waveform and state encodings plus default
//                parameter values for the waveform sequencer controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package wave_ctrl_pkg;

    localparam int DEF_ACC_W      = 16;
    localparam int DEF_PRIME_LAT  = 2;
    localparam int DEF_SWITCH_LAT = 1;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_START = 2'b01,
        OP_STOP  = 2'b10,
        OP_SET   = 2'b11
    } cmd_op_e;

    // Waveform ROM select codes carried on cmd_wave / rom_select
    localparam logic [1:0] WAVE_TRI     = 2'b00;
    localparam logic [1:0] WAVE_REV_TRI = 2'b01;
    localparam logic [1:0] WAVE_SQUARE  = 2'b10;
    localparam logic [1:0] WAVE_COSINE  = 2'b11;

    // Controller state encoding, visible on the state output
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_PRIME  = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;
    localparam logic [1:0] ST_SWITCH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/wave_seq_ctrl_phase_acc.sv
`default_nettype none
// ============================================================================
//  Module      : phase_acc
//  Description : Phase accumulator with synchronous clear and enable. Exposes
//                the top 8 bits as the ROM address and flags the add that
//                carries out of the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [ACC_W-1:0] ftw,
    output logic [7:0]       phase,
    output logic             wrap
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, ftw};
    assign phase = acc[ACC_W-1:ACC_W-8];
    // A clear wins over the add, so no carry is reported in that cycle
    assign wrap  = enable && !clear && sum[ACC_W];

    // Accumulate modulo 2^ACC_W while enabled; clear returns to zero phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wave_seq_ctrl
//  Description : Command-driven DDS sequencer. Primes the waveform ROM, runs
//                the phase accumulator, and applies queued (wave, ftw) updates
//                on a phase wrap, blanking amplitude across a ROM switch.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_seq_ctrl
    import wave_ctrl_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int PRIME_LAT  = DEF_PRIME_LAT,
    parameter int SWITCH_LAT = DEF_SWITCH_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_wave,
    input  logic [ACC_W-1:0] cmd_ftw,
    output logic             rom_en,
    output logic [1:0]       rom_select,
    output logic [7:0]       rom_phase,
    output logic             amp_valid,
    output logic             wrap,
    output logic [1:0]       state
);

    localparam int               CNT_W       = 8;
    localparam logic [CNT_W-1:0] PRIME_LOAD  = CNT_W'(PRIME_LAT - 1);
    localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_LAT - 1);

    logic [1:0]       cur_state;
    logic [1:0]       active_wave;
    logic [ACC_W-1:0] active_ftw;
    logic             pend_valid;
    logic [1:0]       pend_wave;
    logic [ACC_W-1:0] pend_ftw;
    logic [CNT_W-1:0] prime_cnt;
    logic [CNT_W-1:0] switch_cnt;

    logic accept;
    logic is_start;
    logic is_stop;
    logic is_set;
    logic do_apply;
    logic wave_change;

    // Handshake decode and pending-apply qualification
    always_comb begin
        cmd_ready   = (cur_state != ST_PRIME);
        accept      = cmd_valid && cmd_ready;
        is_start    = accept && (cmd_op == OP_START);
        is_stop     = accept && (cmd_op == OP_STOP);
        is_set      = accept && (cmd_op == OP_SET);
        // With a zero tuning word the phase never wraps, so apply at once
        do_apply    = pend_valid
                      && ((cur_state == ST_RUN) || (cur_state == ST_SWITCH))
                      && (wrap || (active_ftw == '0));
        wave_change = do_apply && (pend_wave != active_wave);
    end

    assign rom_en     = (cur_state != ST_IDLE);
    assign amp_valid  = (cur_state == ST_RUN);
    assign rom_select = active_wave;
    assign state      = cur_state;

    phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (is_stop),
        .enable (rom_en),
        .ftw    (active_ftw),
        .phase  (rom_phase),
        .wrap   (wrap)
    );

    // Sequencer FSM, active configuration and one-deep pending slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= ST_IDLE;
            active_wave <= 2'b00;
            active_ftw  <= '0;
            pend_valid  <= 1'b0;
            pend_wave   <= 2'b00;
            pend_ftw    <= '0;
            prime_cnt   <= '0;
            switch_cnt  <= '0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (is_set) begin
                        active_wave <= cmd_wave;
                        active_ftw  <= cmd_ftw;
                    end
                    if (is_start) begin
                        cur_state <= ST_PRIME;
                        prime_cnt <= PRIME_LOAD;
                    end
                end
                ST_PRIME: begin
                    if (prime_cnt == '0) begin
                        cur_state <= ST_RUN;
                    end else begin
                        prime_cnt <= prime_cnt - CNT_W'(1);
                    end
                end
                ST_RUN, ST_SWITCH: begin
                    if (is_stop) begin
                        cur_state  <= ST_IDLE;
                        pend_valid <= 1'b0;
                    end else begin
                        if (cur_state == ST_SWITCH) begin
                            if (switch_cnt == '0) begin
                                cur_state <= ST_RUN;
                            end else begin
                                switch_cnt <= switch_cnt - CNT_W'(1);
                            end
                        end
                        if (do_apply) begin
                            active_wave <= pend_wave;
                            active_ftw  <= pend_ftw;
                            pend_valid  <= 1'b0;
                            // A new ROM needs its own settling window
                            if (wave_change) begin
                                cur_state  <= ST_SWITCH;
                                switch_cnt <= SWITCH_LOAD;
                            end
                        end
                        // A SET in the apply cycle queues behind the applied one
                        if (is_set) begin
                            pend_valid <= 1'b1;
                            pend_wave  <= cmd_wave;
                            pend_ftw   <= cmd_ftw;
                        end
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_seq_ctrl
//  Description : Self-checking bench for wave_seq_ctrl with directed scenarios
//                and randomized commands against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_seq_ctrl;

    localparam int AW   = 16;
    localparam int PL   = 2;
    localparam int SL   = 1;
    localparam int MODV = 65536;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] STOP  = 2'b10;
    localparam logic [1:0] SET   = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_wave;
    logic [15:0] cmd_ftw;
    logic        rom_en;
    logic [1:0]  rom_select;
    logic [7:0]  rom_phase;
    logic        amp_valid;
    logic        wrap;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 idle, 1 priming, 2 running, 3 blanking
    int         m_mode;
    int         m_acc;
    int         m_ftw;
    int         m_pf;
    int         m_prime_left;
    int         m_blank_left;
    logic [1:0] m_wave;
    logic [1:0] m_pw;
    bit         m_pv;

    logic       exp_ready, exp_en, exp_amp, exp_wrap;
    logic [1:0] exp_sel, exp_state;
    logic [7:0] exp_phase;

    wave_seq_ctrl #(
        .ACC_W      (AW),
        .PRIME_LAT  (PL),
        .SWITCH_LAT (SL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_wave   (cmd_wave),
        .cmd_ftw    (cmd_ftw),
        .rom_en     (rom_en),
        .rom_select (rom_select),
        .rom_phase  (rom_phase),
        .amp_valid  (amp_valid),
        .wrap       (wrap),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0; m_acc = 0; m_ftw = 0; m_pf = 0;
        m_prime_left = 0; m_blank_left = 0;
        m_wave = 2'b00; m_pw = 2'b00; m_pv = 1'b0;
    endfunction

    function automatic void model_outputs();
        bit stop_now;
        stop_now  = cmd_valid && (m_mode != 1) && (cmd_op == STOP);
        exp_ready = (m_mode != 1);
        exp_en    = (m_mode != 0);
        exp_amp   = (m_mode == 2);
        exp_sel   = m_wave;
        exp_phase = 8'(m_acc / 256);
        exp_wrap  = exp_en && !stop_now && ((m_acc + m_ftw) >= MODV);
        exp_state = 2'(m_mode);
    endfunction

    function automatic void model_step();
        bit ok;
        bit carry;
        ok    = cmd_valid && (m_mode != 1);
        carry = (m_acc + m_ftw) >= MODV;
        if (m_mode == 0) begin
            if (ok && cmd_op == SET) begin
                m_wave = cmd_wave;
                m_ftw  = int'(cmd_ftw);
            end else if (ok && cmd_op == START) begin
                m_mode = 1; m_prime_left = PL; m_acc = 0;
            end
        end else if (m_mode == 1) begin
            m_acc = (m_acc + m_ftw) % MODV;
            m_prime_left--;
            if (m_prime_left == 0) m_mode = 2;
        end else if (ok && cmd_op == STOP) begin
            m_mode = 0; m_acc = 0; m_pv = 1'b0;
        end else begin
            m_acc = (m_acc + m_ftw) % MODV;
            if (m_mode == 3) begin
                m_blank_left--;
                if (m_blank_left == 0) m_mode = 2;
            end
            if (m_pv && (carry || m_ftw == 0)) begin
                if (m_pw != m_wave) begin
                    m_mode = 3; m_blank_left = SL;
                end
                m_wave = m_pw; m_ftw = m_pf; m_pv = 1'b0;
            end
            if (ok && cmd_op == SET) begin
                m_pv = 1'b1; m_pw = cmd_wave; m_pf = int'(cmd_ftw);
            end
        end
    endfunction

    // Present a command for the current cycle
    task automatic put(input logic v, input logic [1:0] op, input logic [1:0] w, input logic [15:0] f);
        cmd_valid = v; cmd_op = op; cmd_wave = w; cmd_ftw = f;
        #1;
        model_outputs();
    endtask

    // Cross one clock edge; the model follows the inputs the DUT sampled
    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = NOP; cmd_wave = 2'b00; cmd_ftw = 16'h0;
        #1;
        model_outputs();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready} !== {2'b00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", {state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready}, 16'h0001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        model_outputs();
    endtask

    task automatic test_basic();
        int last;
        int nwrap;
        put(1'b1, SET, 2'b11, 16'h0100);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", cmd_ready); end
        adv();
        checks++;
        if (rom_select !== 2'b11) begin failures++; $display("FAIL idle_set_sel got=%b exp=11", rom_select); end
        put(1'b1, START, 2'b00, 16'h0);
        adv();
        checks++;
        if ({state, rom_en, amp_valid, rom_phase} !== {2'b01, 1'b1, 1'b0, 8'h00}) begin
            failures++; $display("FAIL basic_cyc1 got=%h exp=%h", {state, rom_en, amp_valid, rom_phase}, {2'b01, 1'b1, 1'b0, 8'h00});
        end
        adv();
        checks++;
        if ({state, amp_valid, rom_phase} !== {2'b01, 1'b0, 8'h01}) begin
            failures++; $display("FAIL basic_cyc2 got=%h exp=%h", {state, amp_valid, rom_phase}, {2'b01, 1'b0, 8'h01});
        end
        adv();
        checks++;
        if ({state, amp_valid, rom_phase} !== {2'b10, 1'b1, 8'h02}) begin
            failures++; $display("FAIL basic_cyc3 got=%h exp=%h", {state, amp_valid, rom_phase}, {2'b10, 1'b1, 8'h02});
        end
        last = -1;
        nwrap = 0;
        for (int i = 0; i < 600; i++) begin
            adv();
            checks++;
            if ({state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready} !== {exp_state, exp_en, exp_sel, exp_phase, exp_amp, exp_wrap, exp_ready}) begin
                failures++;
                $display("FAIL basic_run i=%0d got=%h exp=%h", i, {state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready}, {exp_state, exp_en, exp_sel, exp_phase, exp_amp, exp_wrap, exp_ready});
            end
            if (wrap === 1'b1) begin
                checks++;
                if (rom_phase !== 8'hFF) begin failures++; $display("FAIL basic_wrap_phase got=%h exp=ff", rom_phase); end
                if (last >= 0) begin
                    checks++;
                    if (i - last != 256) begin failures++; $display("FAIL basic_wrap_period got=%0d exp=256", i - last); end
                end
                last = i;
                nwrap++;
            end
        end
        checks++;
        if (nwrap != 2) begin failures++; $display("FAIL basic_wrap_count got=%0d exp=2", nwrap); end
    endtask

    task automatic test_switch();
        put(1'b1, STOP, 2'b00, 16'h0);
        adv();
        checks++;
        if ({state, rom_en, rom_phase, amp_valid, rom_select} !== {2'b00, 1'b0, 8'h00, 1'b0, 2'b11}) begin
            failures++; $display("FAIL stop_run got=%h exp=%h", {state, rom_en, rom_phase, amp_valid, rom_select}, {2'b00, 1'b0, 8'h00, 1'b0, 2'b11});
        end
        put(1'b1, SET, 2'b11, 16'h4000); adv();
        put(1'b1, START, 2'b00, 16'h0); adv();
        adv(); adv();
        checks++;
        if ({state, rom_phase} !== {2'b10, 8'h80}) begin failures++; $display("FAIL switch_run got=%h exp=%h", {state, rom_phase}, {2'b10, 8'h80}); end
        put(1'b1, SET, 2'b10, 16'h8000);
        adv();
        checks++;
        if ({wrap, rom_select, amp_valid, rom_phase} !== {1'b1, 2'b11, 1'b1, 8'hC0}) begin
            failures++; $display("FAIL switch_wrap got=%h exp=%h", {wrap, rom_select, amp_valid, rom_phase}, {1'b1, 2'b11, 1'b1, 8'hC0});
        end
        adv();
        checks++;
        if ({state, rom_select, amp_valid, rom_phase} !== {2'b11, 2'b10, 1'b0, 8'h00}) begin
            failures++; $display("FAIL switch_blank got=%h exp=%h", {state, rom_select, amp_valid, rom_phase}, {2'b11, 2'b10, 1'b0, 8'h00});
        end
        adv();
        checks++;
        if ({state, amp_valid, rom_phase, wrap} !== {2'b10, 1'b1, 8'h80, 1'b1}) begin
            failures++; $display("FAIL switch_resume got=%h exp=%h", {state, amp_valid, rom_phase, wrap}, {2'b10, 1'b1, 8'h80, 1'b1});
        end
        adv();
        checks++;
        if (rom_phase !== 8'h00) begin failures++; $display("FAIL switch_step got=%h exp=00", rom_phase); end
    endtask

    task automatic test_last_wins();
        bit seen;
        put(1'b1, STOP, 2'b00, 16'h0); adv();
        put(1'b1, SET, 2'b00, 16'h1000); adv();
        put(1'b1, START, 2'b00, 16'h0); adv();
        adv(); adv();
        put(1'b1, SET, 2'b01, 16'h2000); adv();
        put(1'b1, SET, 2'b00, 16'h0800); adv();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            checks++;
            if ({amp_valid, rom_select, state} !== {1'b1, 2'b00, 2'b10}) begin
                failures++; $display("FAIL last_wins_hold got=%h exp=%h", {amp_valid, rom_select, state}, {1'b1, 2'b00, 2'b10});
            end
            if (wrap === 1'b1) seen = 1'b1;
            else adv();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL last_wins_timeout got=no_wrap exp=wrap"); end
        adv();
        checks++;
        if ({state, amp_valid, rom_select, rom_phase} !== {2'b10, 1'b1, 2'b00, 8'h00}) begin
            failures++; $display("FAIL last_wins_apply got=%h exp=%h", {state, amp_valid, rom_select, rom_phase}, {2'b10, 1'b1, 2'b00, 8'h00});
        end
        adv();
        checks++;
        if ({state, amp_valid, rom_phase} !== {2'b10, 1'b1, 8'h08}) begin
            failures++; $display("FAIL last_wins_step got=%h exp=%h", {state, amp_valid, rom_phase}, {2'b10, 1'b1, 8'h08});
        end
    endtask

    task automatic test_ftw_zero();
        put(1'b1, STOP, 2'b00, 16'h0); adv();
        put(1'b1, SET, 2'b00, 16'h0000); adv();
        put(1'b1, START, 2'b00, 16'h0); adv();
        adv(); adv();
        put(1'b1, SET, 2'b00, 16'h0200);
        adv();
        checks++;
        if ({rom_phase, wrap, state} !== {8'h00, 1'b0, 2'b10}) begin
            failures++; $display("FAIL zero_accept got=%h exp=%h", {rom_phase, wrap, state}, {8'h00, 1'b0, 2'b10});
        end
        adv();
        checks++;
        if (rom_phase !== 8'h00) begin failures++; $display("FAIL zero_apply got=%h exp=00", rom_phase); end
        adv();
        checks++;
        if (rom_phase !== 8'h02) begin failures++; $display("FAIL zero_step1 got=%h exp=02", rom_phase); end
        adv();
        checks++;
        if ({rom_phase, amp_valid} !== {8'h04, 1'b1}) begin failures++; $display("FAIL zero_step2 got=%h exp=%h", {rom_phase, amp_valid}, {8'h04, 1'b1}); end
    endtask

    task automatic test_start_ignored();
        put(1'b1, START, 2'b00, 16'h0);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL start_run_ready got=%b exp=1", cmd_ready); end
        adv();
        checks++;
        if ({state, amp_valid, rom_phase} !== {2'b10, 1'b1, 8'h06}) begin
            failures++; $display("FAIL start_ignored got=%h exp=%h", {state, amp_valid, rom_phase}, {2'b10, 1'b1, 8'h06});
        end
    endtask

    task automatic test_stop_prime();
        put(1'b1, STOP, 2'b00, 16'h0); adv();
        put(1'b1, START, 2'b00, 16'h0); adv();
        put(1'b1, STOP, 2'b00, 16'h0);
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL prime_ready1 got=%b exp=0", cmd_ready); end
        adv();
        checks++;
        if ({state, rom_en} !== {2'b01, 1'b1}) begin failures++; $display("FAIL prime_hold got=%h exp=%h", {state, rom_en}, {2'b01, 1'b1}); end
        put(1'b1, STOP, 2'b00, 16'h0);
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL prime_ready2 got=%b exp=0", cmd_ready); end
        adv();
        put(1'b1, STOP, 2'b00, 16'h0);
        checks++;
        if ({state, cmd_ready} !== {2'b10, 1'b1}) begin failures++; $display("FAIL prime_to_run got=%h exp=%h", {state, cmd_ready}, {2'b10, 1'b1}); end
        adv();
        checks++;
        if ({state, rom_en, rom_phase, amp_valid} !== {2'b00, 1'b0, 8'h00, 1'b0}) begin
            failures++; $display("FAIL prime_stop got=%h exp=%h", {state, rom_en, rom_phase, amp_valid}, {2'b00, 1'b0, 8'h00, 1'b0});
        end
    endtask

    task automatic test_reset_mid_run();
        put(1'b1, START, 2'b00, 16'h0); adv();
        for (int i = 0; i < 5; i++) adv();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready} !== {2'b00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_run got=%h exp=%h", {state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready}, 16'h0001);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        model_outputs();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({state, rom_en} !== {2'b00, 1'b0}) begin failures++; $display("FAIL reset_no_restart got=%h exp=0", {state, rom_en}); end
            adv();
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [1:0]  op;
        logic [1:0]  w;
        logic [15:0] f;
        int          r;
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 99) < 40);
            r = $urandom_range(0, 99);
            op = (r < 30) ? START : (r < 70) ? SET : (r < 78) ? STOP : NOP;
            w = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       f = 16'h0000;
                1:       f = 16'($urandom_range(0, 65535));
                2:       f = 16'($urandom_range(1, 15)) << 12;
                default: f = 16'($urandom_range(1, 255)) << 8;
            endcase
            put(v, op, w, f);
            checks++;
            if ({state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready} !== {exp_state, exp_en, exp_sel, exp_phase, exp_amp, exp_wrap, exp_ready}) begin
                failures++;
                $display("FAIL random i=%0d got=%h exp=%h", i, {state, rom_en, rom_select, rom_phase, amp_valid, wrap, cmd_ready}, {exp_state, exp_en, exp_sel, exp_phase, exp_amp, exp_wrap, exp_ready});
            end
            adv();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_wave  = 2'b00;
        cmd_ftw   = 16'h0;
        model_reset();
        test_reset();
        test_basic();
        test_switch();
        test_last_wins();
        test_ftw_zero();
        test_start_ignored();
        test_stop_prime();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
